// File: rtl/contador_pkg.sv
// Shared encodings for the parametrised counter: limit-handling modes and direction values.
package contador_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/contador_prescaler.sv
// Count-event prescaler: emits one tick every PRESCALE enabled cycles.
// The phase is cleared by rst or clr and holds while enable is low.
module contador_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Phase advance; the tick is combinational so the parent registers it with the count.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = {CNT_W{1'b0}};
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/contador_param.sv
// Parametrised up/down counter with step, clamped load, wrap/saturate/bounce limits and a tc pulse.
// Optional build macro CONTADOR_PRESCALER_EN inserts a PRESCALE-cycle count-event prescaler.
module contador_param
  import contador_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 255,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up_down,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  conta,
  output logic              tc,
  output logic              dir
);

  localparam int AW = WIDTH + 2;
  localparam logic [WIDTH-1:0]     MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(MAX_VAL);
  localparam logic signed [AW-1:0] MIN_S = AW'(MIN_VAL);
  localparam logic signed [AW-1:0] MAX_S = AW'(MAX_VAL);

  logic [WIDTH-1:0] conta_q, conta_d;
  logic             tc_q, tc_d;
  logic             dir_q, dir_d;
  logic             bdir_q, bdir_d;

  logic                     count_ev_s;
  logic                     up_s;
  logic signed [AW-1:0]     cur_s;
  logic signed [AW-1:0]     stp_s;
  logic signed [AW-1:0]     next_s;
  logic [WIDTH-1:0]         load_clamp_s;

`ifdef CONTADOR_PRESCALER_EN
  logic tick_s;

  contador_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .enable (enable),
    .tick   (tick_s)
  );

  assign count_ev_s = enable & tick_s;
`else
  // An illegal PRESCALE setting is treated defensively as "never count".
  localparam logic PRESCALE_LEGAL = (PRESCALE >= 1);
  assign count_ev_s = enable & PRESCALE_LEGAL;
`endif

  // Candidate next value in a widened signed domain so neither overflow nor underflow aliases.
  always_comb begin
    up_s   = (mode == MODE_BOUNCE) ? bdir_q : up_down;
    cur_s  = signed'({2'b00, conta_q});
    stp_s  = signed'(AW'(step));
    if (up_s) begin
      next_s = cur_s + stp_s;
    end else begin
      next_s = cur_s - stp_s;
    end
  end

  // Load value clamped into the legal count range.
  always_comb begin
    if (load_val < MIN_W) begin
      load_clamp_s = MIN_W;
    end else if (load_val > MAX_W) begin
      load_clamp_s = MAX_W;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Next-state: load beats counting; tc defaults low so it only lives for one cycle.
  always_comb begin
    conta_d = conta_q;
    tc_d    = 1'b0;
    dir_d   = dir_q;
    bdir_d  = bdir_q;
    if (load) begin
      conta_d = load_clamp_s;
    end else if (count_ev_s) begin
      dir_d = up_s;
      if (step == {STEP_W{1'b0}}) begin
        conta_d = conta_q;
      end else if (next_s > MAX_S) begin
        tc_d = 1'b1;
        case (mode)
          MODE_SAT:    conta_d = MAX_W;
          MODE_BOUNCE: begin
            conta_d = MAX_W;
            bdir_d  = DIR_DOWN;
          end
          default:     conta_d = MIN_W;
        endcase
      end else if (next_s < MIN_S) begin
        tc_d = 1'b1;
        case (mode)
          MODE_SAT:    conta_d = MIN_W;
          MODE_BOUNCE: begin
            conta_d = MIN_W;
            bdir_d  = DIR_UP;
          end
          default:     conta_d = MAX_W;
        endcase
      end else begin
        conta_d = next_s[WIDTH-1:0];
      end
    end else begin
      conta_d = conta_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      conta_q <= MIN_W;
      tc_q    <= 1'b0;
      dir_q   <= DIR_UP;
      bdir_q  <= DIR_UP;
    end else begin
      conta_q <= conta_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
      bdir_q  <= bdir_d;
    end
  end

  assign conta = conta_q;
  assign tc    = tc_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param (MIN=10, MAX=20): directed scenarios plus random traffic
// checked against an integer reference model; prescaler checks apply when CONTADOR_PRESCALER_EN is set.
module tb_contador_param;

  localparam int MINV = 10;
  localparam int MAXV = 20;
  localparam int PRE  = 4;
`ifdef CONTADOR_PRESCALER_EN
  localparam int EV = PRE;
`else
  localparam int EV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [3:0] step = 4'd0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] conta;
  logic       tc;
  logic       dir;

  int n_pass = 0;
  int n_total = 0;

  int m_conta = MINV;
  bit m_tc = 0, m_dir = 1, m_bdir = 1;
  int m_pre = 0;

  contador_param #(
    .WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP_W(4), .PRESCALE(PRE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .mode(mode),
    .step(step), .load(load), .load_val(load_val),
    .conta(conta), .tc(tc), .dir(dir)
  );

  always #5 clk = ~clk;

  // Reference model: one clock of the counter's rules in plain integer arithmetic.
  function automatic void model_step(input bit r, input bit ld, input bit en, input bit ud,
                                     input int md, input int st, input int lv);
    int n;
    bit up;
    if (r) begin
      m_conta = MINV; m_tc = 0; m_dir = 1; m_bdir = 1; m_pre = 0;
      return;
    end
    if (ld) begin
      m_conta = (lv < MINV) ? MINV : ((lv > MAXV) ? MAXV : lv);
      m_tc = 0; m_pre = 0;
      return;
    end
    m_tc = 0;
    if (!en) return;
`ifdef CONTADOR_PRESCALER_EN
    if (m_pre != PRE - 1) begin
      m_pre++;
      return;
    end
    m_pre = 0;
`endif
    up = (md == 2) ? m_bdir : ud;
    m_dir = up;
    if (st == 0) return;
    n = up ? m_conta + st : m_conta - st;
    if (n > MAXV) begin
      m_tc = 1;
      m_conta = (md == 1 || md == 2) ? MAXV : MINV;
      if (md == 2) m_bdir = 0;
    end else if (n < MINV) begin
      m_tc = 1;
      m_conta = (md == 1 || md == 2) ? MINV : MAXV;
      if (md == 2) m_bdir = 1;
    end else begin
      m_conta = n;
    end
  endfunction

  task automatic cyc(input bit r, input bit ld, input bit en, input bit ud,
                     input int md, input int st, input int lv);
    rst = r; load = ld; enable = en; up_down = ud;
    mode = 2'(md); step = 4'(st); load_val = 8'(lv);
    @(posedge clk);
    model_step(r, ld, en, ud, md, st, lv);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 5, 99);
    n_total++;
    if (conta !== 8'd10) $display("FAIL reset_conta: got %0d want 10", conta); else n_pass++;
    n_total++;
    if (tc !== 1'b0 || dir !== 1'b1) $display("FAIL reset_flags: got tc=%b dir=%b want tc=0 dir=1", tc, dir);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int exp_v[4] = '{13, 16, 19, 10};
    for (int e = 0; e < 4; e++) begin
      for (int c = 0; c < EV; c++) begin
        cyc(0, 0, 1, 1, 0, 3, 0);
        n_total++;
        if ({conta, tc, dir} !== {8'(m_conta), m_tc, m_dir})
          $display("FAIL wrap_model: got %0d/%b/%b want %0d/%b/%b", conta, tc, dir, m_conta, m_tc, m_dir);
        else n_pass++;
      end
      n_total++;
      if (conta !== 8'(exp_v[e]) || tc !== (e == 3))
        $display("FAIL wrap_seq[%0d]: got conta=%0d tc=%b want conta=%0d tc=%b", e, conta, tc, exp_v[e], (e == 3));
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    cyc(0, 1, 0, 0, 1, 4, 12);
    for (int e = 0; e < 3; e++) begin
      repeat (EV) cyc(0, 0, 1, 0, 1, 4, 0);
      n_total++;
      if (conta !== 8'd10 || tc !== 1'b1 || dir !== 1'b0)
        $display("FAIL sat_down[%0d]: got %0d/%b/%b want 10/1/0", e, conta, tc, dir);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int ev[7]  = '{15, 20, 20, 15, 10, 10, 15};
    bit etc[7] = '{0, 0, 1, 0, 0, 1, 0};
    bit edr[7] = '{1, 1, 1, 0, 0, 0, 1};
    cyc(0, 1, 0, 1, 2, 5, 10);
    for (int e = 0; e < 7; e++) begin
      repeat (EV) cyc(0, 0, 1, 1'($urandom), 2, 5, 0);
      n_total++;
      if (conta !== 8'(ev[e]) || tc !== etc[e] || dir !== edr[e])
        $display("FAIL bounce[%0d]: got %0d/%b/%b want %0d/%b/%b", e, conta, tc, dir, ev[e], etc[e], edr[e]);
      else n_pass++;
    end
  endtask

  task automatic test_load_priority();
    cyc(0, 1, 1, 1, 0, 3, 250);
    n_total++;
    if (conta !== 8'd20 || tc !== 1'b0) $display("FAIL load_clamp: got %0d/%b want 20/0", conta, tc);
    else n_pass++;
    cyc(0, 1, 1, 1, 0, 3, 3);
    n_total++;
    if (conta !== 8'd10) $display("FAIL load_clamp_low: got %0d want 10", conta); else n_pass++;
    cyc(0, 1, 0, 1, 0, 3, 17);
    cyc(1, 1, 1, 1, 0, 3, 250);
    n_total++;
    if (conta !== 8'd10 || dir !== 1'b1) $display("FAIL rst_over_load: got %0d/%b want 10/1", conta, dir);
    else n_pass++;
  endtask

  task automatic test_step_zero();
    cyc(0, 1, 0, 1, 1, 0, 20);
    repeat (EV) cyc(0, 0, 1, 1, 1, 0, 0);
    n_total++;
    if (conta !== 8'd20 || tc !== 1'b0) $display("FAIL step_zero: got %0d/%b want 20/0", conta, tc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1'($urandom), $urandom_range(3), $urandom_range(15), 0);
      n_total++;
      if (conta !== 8'd20 || tc !== 1'b0) $display("FAIL hold[%0d]: got %0d/%b want 20/0", i, conta, tc);
      else n_pass++;
    end
  endtask

`ifdef CONTADOR_PRESCALER_EN
  task automatic test_prescaler();
    int chg[$];
    logic [7:0] prev;
    cyc(0, 1, 0, 1, 0, 1, 10);
    prev = conta;
    for (int k = 1; k <= 14; k++) begin
      cyc(0, 0, !(k == 9 || k == 10), 1, 0, 1, 0);
      if (conta !== prev) chg.push_back(k);
      prev = conta;
    end
    n_total++;
    if (chg.size() != 3 || chg[0] != 4 || chg[1] != 8 || chg[2] != 14)
      $display("FAIL prescale_timing: got %0d changes (first at %0d) want changes at 4,8,14",
               chg.size(), (chg.size() > 0) ? chg[0] : -1);
    else n_pass++;
    cyc(0, 0, 1, 1, 0, 1, 0);
    cyc(0, 0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0, 1, 15);
    chg.delete();
    prev = conta;
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 1, 1, 0, 1, 0);
      if (conta !== prev) chg.push_back(k);
      prev = conta;
    end
    n_total++;
    if (chg.size() != 1 || chg[0] != 4 || conta !== 8'd16)
      $display("FAIL prescale_load_phase: got %0d changes conta=%0d want one change at 4, conta=16", chg.size(), conta);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(49) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
          1'($urandom), $urandom_range(3), $urandom_range(15), $urandom_range(255));
      n_total++;
      if ({conta, tc, dir} !== {8'(m_conta), m_tc, m_dir})
        $display("FAIL random[%0d]: got %0d/%b/%b want %0d/%b/%b", i, conta, tc, dir, m_conta, m_tc, m_dir);
      else n_pass++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_wrap();
    test_saturate();
    test_bounce();
    test_load_priority();
    test_step_zero();
`ifdef CONTADOR_PRESCALER_EN
    test_prescaler();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
